reorder_buffer: RTL and testbench

Circular reorder buffer at the consuming end of the dispatch path: accepts one renamed instruction per cycle from decode/rename/dispatch, hands back its ROB tag, records writeback results by tag, and retires completed entries strictly in program order. Retirement drives the ARF write and the RAT "mark rd as retired" port, the reverse of dispatch marking rd speculative. Also serves tag-indexed operand reads for rename-time source resolution.

---
 rtl/reorder_buffer.sv | 121 ++++++++++++
 tb/tb_reorder_buffer.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: tag allocation at dispatch, writeback by tag, in-order retirement.
// Optional macro ROB_WB_BYPASS_EN forwards same-cycle writeback data onto the operand read ports.
module reorder_buffer #(
    parameter int DEPTH  = 16,
    parameter int TAG_W  = $clog2(DEPTH),
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dispatch_valid,
    output logic              dispatch_ready,
    input  logic              dispatch_rd_valid,
    input  logic [4:0]        dispatch_rd,
    input  logic              dispatch_is_store,
    output logic [TAG_W-1:0]  dispatch_tag,
    input  logic              wb_valid,
    input  logic [TAG_W-1:0]  wb_tag,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [TAG_W-1:0]  rd_tag0,
    input  logic [TAG_W-1:0]  rd_tag1,
    output logic              rd_ready0,
    output logic              rd_ready1,
    output logic [DATA_W-1:0] rd_data0,
    output logic [DATA_W-1:0] rd_data1,
    output logic              retire_valid,
    output logic [TAG_W-1:0]  retire_tag,
    output logic              retire_rd_valid,
    output logic [4:0]        retire_rd,
    output logic [DATA_W-1:0] retire_data,
    output logic              retire_is_store,
    input  logic              flush
);
    localparam logic [TAG_W:0] L_FULL = (TAG_W+1)'(DEPTH);

    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_done;
    logic [DEPTH-1:0]  r_rd_valid;
    logic [DEPTH-1:0]  r_is_store;
    logic [4:0]        r_rd   [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [TAG_W-1:0]  r_head;
    logic [TAG_W-1:0]  r_tail;
    logic [TAG_W:0]    r_count;

    logic w_fire;
    logic w_retire;
    logic w_wb;

    // Ready ignores a same-cycle retire: a full buffer never accepts, even while draining.
    assign dispatch_ready = (r_count != L_FULL) && !rst;
    assign dispatch_tag   = r_tail;
    assign w_fire         = dispatch_valid && dispatch_ready && !flush;
    assign w_retire       = r_valid[r_head] && r_done[r_head] && !flush;
    assign w_wb           = wb_valid && r_valid[wb_tag] && !flush;

    assign retire_valid    = w_retire;
    assign retire_tag      = r_head;
    assign retire_rd_valid = w_retire && r_rd_valid[r_head];
    assign retire_rd       = r_rd[r_head];
    assign retire_data     = r_data[r_head];
    assign retire_is_store = w_retire && r_is_store[r_head];

    // Control state: pointers, occupancy and per-entry valid/done.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
            r_done  <= '0;
        end else begin
            if (w_fire) begin
                r_valid[r_tail] <= 1'b1;
                r_done[r_tail]  <= 1'b0;
                r_tail          <= r_tail + 1'b1;
            end
            if (w_wb) begin
                r_done[wb_tag] <= 1'b1;
            end
            if (w_retire) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            case ({w_fire, w_retire})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry payload; only meaningful while the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_rd_valid[r_tail] <= dispatch_rd_valid;
            r_rd[r_tail]       <= dispatch_rd;
            r_is_store[r_tail] <= dispatch_is_store;
        end
        if (w_wb) begin
            r_data[wb_tag] <= wb_data;
        end
    end

    always_comb begin
        rd_ready0 = r_valid[rd_tag0] && r_done[rd_tag0];
        rd_data0  = r_data[rd_tag0];
        rd_ready1 = r_valid[rd_tag1] && r_done[rd_tag1];
        rd_data1  = r_data[rd_tag1];
`ifdef ROB_WB_BYPASS_EN
        if (wb_valid && (wb_tag == rd_tag0) && r_valid[rd_tag0]) begin
            rd_ready0 = 1'b1;
            rd_data0  = wb_data;
        end
        if (wb_valid && (wb_tag == rd_tag1) && r_valid[rd_tag1]) begin
            rd_ready1 = 1'b1;
            rd_data1  = wb_data;
        end
`endif
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed testbench for reorder_buffer: reset, in-order retire, wrap/full, flush, read ports.
module tb_reorder_buffer;
    localparam int DEPTH  = 16;
    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              dispatch_valid;
    logic              dispatch_ready;
    logic              dispatch_rd_valid;
    logic [4:0]        dispatch_rd;
    logic              dispatch_is_store;
    logic [TAG_W-1:0]  dispatch_tag;
    logic              wb_valid;
    logic [TAG_W-1:0]  wb_tag;
    logic [DATA_W-1:0] wb_data;
    logic [TAG_W-1:0]  rd_tag0;
    logic [TAG_W-1:0]  rd_tag1;
    logic              rd_ready0;
    logic              rd_ready1;
    logic [DATA_W-1:0] rd_data0;
    logic [DATA_W-1:0] rd_data1;
    logic              retire_valid;
    logic [TAG_W-1:0]  retire_tag;
    logic              retire_rd_valid;
    logic [4:0]        retire_rd;
    logic [DATA_W-1:0] retire_data;
    logic              retire_is_store;
    logic              flush;

    int checks = 0;
    int errors = 0;

    reorder_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_rd_valid(dispatch_rd_valid), .dispatch_rd(dispatch_rd),
        .dispatch_is_store(dispatch_is_store), .dispatch_tag(dispatch_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .rd_tag0(rd_tag0), .rd_tag1(rd_tag1),
        .rd_ready0(rd_ready0), .rd_ready1(rd_ready1),
        .rd_data0(rd_data0), .rd_data1(rd_data1),
        .retire_valid(retire_valid), .retire_tag(retire_tag),
        .retire_rd_valid(retire_rd_valid), .retire_rd(retire_rd),
        .retire_data(retire_data), .retire_is_store(retire_is_store),
        .flush(flush)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        dispatch_valid    = 1'b0;
        dispatch_rd_valid = 1'b0;
        dispatch_rd       = 5'd0;
        dispatch_is_store = 1'b0;
        wb_valid          = 1'b0;
        wb_tag            = '0;
        wb_data           = '0;
        flush             = 1'b0;
    endtask

    task automatic disp(input logic rdv, input logic [4:0] rd, input logic st);
        dispatch_valid    = 1'b1;
        dispatch_rd_valid = rdv;
        dispatch_rd       = rd;
        dispatch_is_store = st;
    endtask

    task automatic wb(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        wb_valid = 1'b1;
        wb_tag   = t;
        wb_data  = d;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        settle();
    endtask

    task automatic test_reset();
        idle();
        rd_tag0 = '0;
        rd_tag1 = '0;
        rst = 1'b1;
        tick();
        settle();
        checks++;
        if (dispatch_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready_in_rst got %b want 0", dispatch_ready);
        end
        tick();
        rst = 1'b0;
        settle();
        checks++;
        if (dispatch_ready !== 1'b1 || dispatch_tag !== 4'd0) begin
            errors++; $display("FAIL reset_ready_after got %b/%0d want 1/0", dispatch_ready, dispatch_tag);
        end
        checks++;
        if ({retire_valid, retire_rd_valid, retire_is_store, rd_ready0, rd_ready1} !== 5'b0) begin
            errors++; $display("FAIL reset_outputs got %b want 00000",
                {retire_valid, retire_rd_valid, retire_is_store, rd_ready0, rd_ready1});
        end
    endtask

    task automatic test_basic();
        do_reset();
        disp(1'b1, 5'd5, 1'b0);
        settle();
        checks++;
        if (dispatch_tag !== 4'd0) begin
            errors++; $display("FAIL basic_tag got %0d want 0", dispatch_tag);
        end
        tick();
        idle();
        wb(4'd0, 32'hDEADBEEF);
        settle();
        checks++;
        if (retire_valid !== 1'b0) begin
            errors++; $display("FAIL basic_no_retire_in_wb got %b want 0", retire_valid);
        end
        tick();
        idle();
        settle();
        checks++;
        if (retire_valid !== 1'b1 || retire_rd_valid !== 1'b1 || retire_rd !== 5'd5 ||
            retire_data !== 32'hDEADBEEF || retire_tag !== 4'd0) begin
            errors++; $display("FAIL basic_retire got v%b rv%b rd%0d d%h t%0d want v1 rv1 rd5 dDEADBEEF t0",
                retire_valid, retire_rd_valid, retire_rd, retire_data, retire_tag);
        end
        tick();
        settle();
        checks++;
        if (retire_valid !== 1'b0 || retire_rd_valid !== 1'b0) begin
            errors++; $display("FAIL basic_after_retire got %b%b want 00", retire_valid, retire_rd_valid);
        end
    endtask

    task automatic test_out_of_order();
        logic [DATA_W-1:0] exp_d [3];
        exp_d[0] = 32'h10; exp_d[1] = 32'h11; exp_d[2] = 32'h22;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            disp(1'b1, 5'(i + 1), 1'b0);
            settle();
            checks++;
            if (dispatch_tag !== 4'(i)) begin
                errors++; $display("FAIL ooo_tag got %0d want %0d", dispatch_tag, i);
            end
            tick();
        end
        idle();
        wb(4'd2, exp_d[2]);
        tick();
        wb(4'd1, exp_d[1]);
        rd_tag0 = 4'd2;
        settle();
        checks++;
        if (retire_valid !== 1'b0) begin
            errors++; $display("FAIL ooo_wait2 got %b want 0", retire_valid);
        end
        checks++;
        if (rd_ready0 !== 1'b1 || rd_data0 !== exp_d[2]) begin
            errors++; $display("FAIL ooo_readport got %b/%h want 1/%h", rd_ready0, rd_data0, exp_d[2]);
        end
        tick();
        wb(4'd0, exp_d[0]);
        settle();
        checks++;
        if (retire_valid !== 1'b0) begin
            errors++; $display("FAIL ooo_wait1 got %b want 0", retire_valid);
        end
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++;
            if (retire_valid !== 1'b1 || retire_tag !== 4'(i) || retire_rd !== 5'(i + 1) ||
                retire_data !== exp_d[i]) begin
                errors++; $display("FAIL ooo_retire%0d got v%b t%0d rd%0d d%h want v1 t%0d rd%0d d%h",
                    i, retire_valid, retire_tag, retire_rd, retire_data, i, i + 1, exp_d[i]);
            end
            tick();
        end
        settle();
        checks++;
        if (retire_valid !== 1'b0) begin
            errors++; $display("FAIL ooo_drained got %b want 0", retire_valid);
        end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            disp(i != 0, 5'(i), i == 0);
            settle();
            checks++;
            if (dispatch_ready !== 1'b1 || dispatch_tag !== 4'(i)) begin
                errors++; $display("FAIL full_fill%0d got %b/%0d want 1/%0d", i, dispatch_ready, dispatch_tag, i);
            end
            tick();
        end
        disp(1'b1, 5'd9, 1'b0);
        settle();
        checks++;
        if (dispatch_ready !== 1'b0) begin
            errors++; $display("FAIL full_ready got %b want 0", dispatch_ready);
        end
        wb(4'd0, 32'h1234);
        tick();
        wb_valid = 1'b0;
        settle();
        checks++;
        if (retire_valid !== 1'b1 || retire_is_store !== 1'b1 || retire_rd_valid !== 1'b0 ||
            dispatch_ready !== 1'b0) begin
            errors++; $display("FAIL full_retire_store got v%b st%b rv%b rdy%b want 1 1 0 0",
                retire_valid, retire_is_store, retire_rd_valid, dispatch_ready);
        end
        tick();
        settle();
        checks++;
        if (dispatch_ready !== 1'b1 || dispatch_tag !== 4'd0 || retire_valid !== 1'b0) begin
            errors++; $display("FAIL full_wrap got rdy%b t%0d rv%b want 1 0 0",
                dispatch_ready, dispatch_tag, retire_valid);
        end
        tick();
        idle();
        settle();
        checks++;
        if (dispatch_ready !== 1'b0) begin
            errors++; $display("FAIL full_refill got %b want 0", dispatch_ready);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            disp(1'b1, 5'(i), 1'b0);
            tick();
        end
        idle();
        wb(4'd0, 32'hA0);
        tick();
        idle();
        disp(1'b1, 5'd20, 1'b0);
        settle();
        checks++;
        if (dispatch_tag !== 4'd8 || retire_valid !== 1'b1 || retire_tag !== 4'd0) begin
            errors++; $display("FAIL b2b_same_cycle got t%0d rv%b rt%0d want 8 1 0",
                dispatch_tag, retire_valid, retire_tag);
        end
        tick();
        idle();
        settle();
        checks++;
        if (dispatch_tag !== 4'd9 || retire_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_advance got t%0d rv%b want 9 0", dispatch_tag, retire_valid);
        end
        for (int i = 0; i < 8; i++) begin
            disp(1'b0, 5'd0, 1'b0);
            settle();
            checks++;
            if (dispatch_ready !== 1'b1 || dispatch_tag !== 4'((9 + i) % DEPTH)) begin
                errors++; $display("FAIL b2b_fill%0d got %b/%0d want 1/%0d",
                    i, dispatch_ready, dispatch_tag, (9 + i) % DEPTH);
            end
            tick();
        end
        idle();
        settle();
        checks++;
        if (dispatch_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_count8 got %b want 0", dispatch_ready);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            disp(1'b1, 5'(i), 1'b0);
            tick();
        end
        idle();
        wb(4'd0, 32'h55);
        tick();
        flush = 1'b1;
        wb(4'd1, 32'h66);
        disp(1'b1, 5'd7, 1'b0);
        settle();
        checks++;
        if (retire_valid !== 1'b0) begin
            errors++; $display("FAIL flush_no_retire got %b want 0", retire_valid);
        end
        tick();
        idle();
        rd_tag0 = 4'd1;
        rd_tag1 = 4'd5;
        settle();
        checks++;
        if (retire_valid !== 1'b0 || dispatch_tag !== 4'd0 || dispatch_ready !== 1'b1 ||
            rd_ready0 !== 1'b0 || rd_ready1 !== 1'b0) begin
            errors++; $display("FAIL flush_state got rv%b t%0d rdy%b r0%b r1%b want 0 0 1 0 0",
                retire_valid, dispatch_tag, dispatch_ready, rd_ready0, rd_ready1);
        end
        for (int i = 0; i < DEPTH; i++) begin
            disp(1'b0, 5'd0, 1'b0);
            tick();
        end
        idle();
        settle();
        checks++;
        if (dispatch_ready !== 1'b0) begin
            errors++; $display("FAIL flush_count0 got %b want 0", dispatch_ready);
        end
    endtask

    task automatic test_read_ports();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            disp(1'b1, 5'(i), 1'b0);
            tick();
        end
        idle();
        rd_tag0 = 4'd3;
        rd_tag1 = 4'd2;
        wb(4'd3, 32'hCAFE0003);
        settle();
        checks++;
`ifdef ROB_WB_BYPASS_EN
        if (rd_ready0 !== 1'b1 || rd_data0 !== 32'hCAFE0003) begin
            errors++; $display("FAIL rp_bypass got %b/%h want 1/CAFE0003", rd_ready0, rd_data0);
        end
`else
        if (rd_ready0 !== 1'b0) begin
            errors++; $display("FAIL rp_nobypass got %b want 0", rd_ready0);
        end
`endif
        tick();
        wb(4'd3, 32'h0BADF00D);
        settle();
        checks++;
        if (rd_ready0 !== 1'b1 || rd_data0 !== (32'hCAFE0003
`ifdef ROB_WB_BYPASS_EN
            ^ 32'hCAFE0003 ^ 32'h0BADF00D
`endif
            ) || rd_ready1 !== 1'b0) begin
            errors++; $display("FAIL rp_registered got %b/%h r1 %b", rd_ready0, rd_data0, rd_ready1);
        end
        tick();
        wb(4'd7, 32'h77);
        rd_tag1 = 4'd7;
        tick();
        idle();
        settle();
        checks++;
        if (rd_data0 !== 32'h0BADF00D || rd_ready1 !== 1'b0) begin
            errors++; $display("FAIL rp_overwrite_invalid got %h/%b want 0BADF00D/0", rd_data0, rd_ready1);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        disp(1'b1, 5'd3, 1'b0);
        tick();
        disp(1'b1, 5'd4, 1'b0);
        wb(4'd0, 32'h99);
        flush = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        rd_tag0 = 4'd0;
        settle();
        checks++;
        if (dispatch_tag !== 4'd0 || retire_valid !== 1'b0 || rd_ready0 !== 1'b0 || dispatch_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid got t%0d rv%b r0%b rdy%b want 0 0 0 1",
                dispatch_tag, retire_valid, rd_ready0, dispatch_ready);
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        rd_tag0 = '0;
        rd_tag1 = '0;
        test_reset();
        test_basic();
        test_out_of_order();
        test_full_wrap();
        test_back_to_back();
        test_flush();
        test_read_ports();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
